// File: rtl/psram16_wb.sv
// Wishbone slave driving an asynchronous-mode cellular PSRAM.
// Each bus cycle maps to exactly one timed access with programmable wait states.
module psram16_wb #(
    parameter int unsigned READ_CYCLES  = 4,
    parameter int unsigned WRITE_CYCLES = 4,
    parameter int unsigned RECOVERY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [31:0] wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic [22:0] mem_addr,
    output logic        mem_clk,
    output logic        mem_cre,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_adv_n,
    output logic        mem_ub_n,
    output logic        mem_lb_n,
    output logic [15:0] mem_data_o,
    input  logic [15:0] mem_data_i,
    output logic        mem_data_oe
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAccess  = 2'd1;
    localparam logic [1:0] StAck     = 2'd2;
    localparam logic [1:0] StRecover = 2'd3;

    localparam logic [3:0] ReadLoad    = 4'(READ_CYCLES - 1);
    localparam logic [3:0] WriteLoad   = 4'(WRITE_CYCLES - 1);
    localparam logic [3:0] RecoverLoad = 4'(RECOVERY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [22:0] addr_q, addr_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        adv_n_q, adv_n_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;
    logic [15:0] wdata_q, wdata_d;
    logic        doe_q, doe_d;
    logic [15:0] rdata_q, rdata_d;

    logic        req;
    logic        unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    // Address decode belongs to the interconnect; upper bits and the byte bit are dropped.
    assign unused_adr = ^{wb_adr_i[31:24], wb_adr_i[0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        adv_n_d = adv_n_q;
        ub_n_d  = ub_n_q;
        lb_n_d  = lb_n_q;
        wdata_d = wdata_q;
        doe_d   = doe_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = wb_adr_i[23:1];
                    ub_n_d  = ~wb_sel_i[1];
                    lb_n_d  = ~wb_sel_i[0];
                    ce_n_d  = 1'b0;
                    adv_n_d = 1'b0;
                    if (wb_we_i) begin
                        we_n_d  = 1'b0;
                        wdata_d = wb_dat_i;
                        doe_d   = 1'b1;
                        cnt_d   = WriteLoad;
                    end else begin
                        oe_n_d = 1'b0;
                        cnt_d  = ReadLoad;
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // OE_n is only low on reads, so it doubles as the access-type flag.
                    if (!oe_n_q) begin
                        rdata_d = mem_data_i;
                    end
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    adv_n_d = 1'b1;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                doe_d = 1'b0;
                if (RECOVERY == 0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = RecoverLoad;
                    state_d = StRecover;
                end
            end
            StRecover: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 23'd0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            adv_n_q <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            wdata_q <= 16'd0;
            doe_q   <= 1'b0;
            rdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            adv_n_q <= adv_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            wdata_q <= wdata_d;
            doe_q   <= doe_d;
            rdata_q <= rdata_d;
        end
    end

    // Ack follows the bus request so an aborted cycle completes silently.
    assign wb_ack_o    = (state_q == StAck) & req;
    assign wb_dat_o    = rdata_q;
    assign mem_addr    = addr_q;
    assign mem_clk     = 1'b0;
    assign mem_cre     = 1'b0;
    assign mem_ce_n    = ce_n_q;
    assign mem_oe_n    = oe_n_q;
    assign mem_we_n    = we_n_q;
    assign mem_adv_n   = adv_n_q;
    assign mem_ub_n    = ub_n_q;
    assign mem_lb_n    = lb_n_q;
    assign mem_data_o  = wdata_q;
    assign mem_data_oe = doe_q;

endmodule

// File: tb/tb_psram16_wb.sv
// Bench for psram16_wb: PSRAM device model, fixed vectors, random traffic
// against a word-level reference memory, and multi-cycle corner sequences.
module tb_psram16_wb;

    localparam int unsigned RdN = 4;
    localparam int unsigned WrN = 3;
    localparam int unsigned Rec = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wb_dat_w, wb_dat_r;
    logic [31:0] wb_adr;
    logic [1:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack;
    logic [22:0] mem_addr;
    logic        mem_clk, mem_cre, mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n, mem_ub_n, mem_lb_n;
    logic [15:0] mem_data_o, mem_data_i;
    logic        mem_data_oe;

    int errors = 0;
    int checks = 0;

    logic [15:0] dev_mem [1024];
    logic [15:0] ref_mem [1024];

    always #5 clk = ~clk;

    psram16_wb #(
        .READ_CYCLES (RdN),
        .WRITE_CYCLES(WrN),
        .RECOVERY    (Rec)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_dat_i   (wb_dat_w),
        .wb_dat_o   (wb_dat_r),
        .wb_adr_i   (wb_adr),
        .wb_sel_i   (wb_sel),
        .wb_we_i    (wb_we),
        .wb_cyc_i   (wb_cyc),
        .wb_stb_i   (wb_stb),
        .wb_ack_o   (wb_ack),
        .mem_addr   (mem_addr),
        .mem_clk    (mem_clk),
        .mem_cre    (mem_cre),
        .mem_ce_n   (mem_ce_n),
        .mem_oe_n   (mem_oe_n),
        .mem_we_n   (mem_we_n),
        .mem_adv_n  (mem_adv_n),
        .mem_ub_n   (mem_ub_n),
        .mem_lb_n   (mem_lb_n),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_data_oe(mem_data_oe)
    );

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 40503 + 7);
    endfunction

    // Asynchronous PSRAM model; word index aliases on the low 10 address bits.
    assign mem_data_i = (!mem_ce_n && !mem_oe_n) ? dev_mem[mem_addr[9:0]] : 16'h0BAD;

    initial begin
        logic [15:0] wd;
        for (int i = 0; i < 1024; i++) dev_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!mem_ce_n && !mem_we_n) begin
                wd = mem_data_oe ? mem_data_o : 16'hF00F;
                if (!mem_ub_n) dev_mem[mem_addr[9:0]][15:8] = wd[15:8];
                if (!mem_lb_n) dev_mem[mem_addr[9:0]][7:0] = wd[7:0];
            end
        end
    end

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic [22:0] exp_addr;
        logic        exp_ub_n;
        logic        exp_lb_n;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [22:0] addr;
        logic        ub_n;
        logic        lb_n;
        logic [7:0]  ce_low;
        logic [7:0]  oe_low;
        logic [7:0]  we_low;
        logic [7:0]  adv_low;
        logic [7:0]  doe_high;
        logic [7:0]  ack_cnt;
        logic [7:0]  ack_k;
        logic [15:0] rdata;
    } meas_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic ref_write(input logic [31:0] adr, input logic [1:0] sel, input logic [15:0] dat);
        if (sel[1]) ref_mem[adr[10:1]][15:8] = dat[15:8];
        if (sel[0]) ref_mem[adr[10:1]][7:0] = dat[7:0];
    endtask

    // Called at a negedge with the DUT idle; observes 16 cycles after the request.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [1:0] sel,
                           input logic [15:0] dat, output meas_t m);
        logic seen;
        m = '0;
        seen = 1'b0;
        wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (!mem_ce_n) begin
                if (!seen) begin
                    m.addr = mem_addr; m.ub_n = mem_ub_n; m.lb_n = mem_lb_n;
                    seen = 1'b1;
                end
                m.ce_low = m.ce_low + 8'd1;
            end
            if (!mem_oe_n) m.oe_low = m.oe_low + 8'd1;
            if (!mem_we_n) m.we_low = m.we_low + 8'd1;
            if (!mem_adv_n) m.adv_low = m.adv_low + 8'd1;
            if (mem_data_oe) m.doe_high = m.doe_high + 8'd1;
            if (wb_ack) begin
                m.ack_cnt = m.ack_cnt + 8'd1;
                m.ack_k = 8'(k);
                m.rdata = wb_dat_r;
                @(posedge clk);
                #1;
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic check_txn(input string tag, input logic we, input logic [31:0] adr,
                             input meas_t m, input logic [22:0] e_addr, input logic e_ub,
                             input logic e_lb, input logic [15:0] e_data);
        int unsigned n;
        n = we ? WrN : RdN;
        check({tag, " addr"}, 32'(m.addr), 32'(e_addr));
        check({tag, " ub_n"}, 32'(m.ub_n), 32'(e_ub));
        check({tag, " lb_n"}, 32'(m.lb_n), 32'(e_lb));
        check({tag, " ce_low"}, 32'(m.ce_low), n);
        check({tag, " adv_low"}, 32'(m.adv_low), n);
        check({tag, " oe_low"}, 32'(m.oe_low), we ? 0 : n);
        check({tag, " we_low"}, 32'(m.we_low), we ? n : 0);
        check({tag, " doe_high"}, 32'(m.doe_high), we ? n + 1 : 0);
        check({tag, " ack_cnt"}, 32'(m.ack_cnt), 1);
        check({tag, " ack_latency"}, 32'(m.ack_k), n + 1);
        if (we) check({tag, " mem_word"}, 32'(dev_mem[adr[10:1]]), 32'(e_data));
        else check({tag, " rdata"}, 32'(m.rdata), 32'(e_data));
    endtask

    initial begin
        vec_t        vecs[10];
        meas_t       m;
        logic [31:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic        we;
        logic        prev_ce;
        int          falls[$];
        int          acks;
        int          cnt_ce, cnt_oe, cnt_any;

        vecs[0] = '{1'b1, 32'h1000_0246, 2'b11, 16'hA5C3, 23'h000123, 1'b0, 1'b0, 16'hA5C3};
        vecs[1] = '{1'b0, 32'h1000_0246, 2'b11, 16'h0000, 23'h000123, 1'b0, 1'b0, 16'hA5C3};
        vecs[2] = '{1'b1, 32'h0000_0800, 2'b11, 16'h1234, 23'h000400, 1'b0, 1'b0, 16'h1234};
        vecs[3] = '{1'b1, 32'h0000_0800, 2'b10, 16'hBE00, 23'h000400, 1'b0, 1'b1, 16'hBE34};
        vecs[4] = '{1'b1, 32'h0000_0800, 2'b01, 16'h0077, 23'h000400, 1'b1, 1'b0, 16'hBE77};
        vecs[5] = '{1'b1, 32'h0000_0800, 2'b00, 16'hFFFF, 23'h000400, 1'b1, 1'b1, 16'hBE77};
        vecs[6] = '{1'b0, 32'h0000_0800, 2'b00, 16'h0000, 23'h000400, 1'b1, 1'b1, 16'hBE77};
        vecs[7] = '{1'b0, 32'hFF00_0800, 2'b11, 16'h0000, 23'h000400, 1'b0, 1'b0, 16'hBE77};
        vecs[8] = '{1'b1, 32'hFF80_0001, 2'b11, 16'h5A5A, 23'h400000, 1'b0, 1'b0, 16'h5A5A};
        vecs[9] = '{1'b0, 32'h0000_0800, 2'b11, 16'h0000, 23'h000400, 1'b0, 1'b0, 16'h5A5A};

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

        // Reset values
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_sel = '0; wb_dat_w = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n, mem_ub_n, mem_lb_n}),
              32'h3F);
        check("rst mem_addr", 32'(mem_addr), 0);
        check("rst mem_data_o", 32'(mem_data_o), 0);
        check("rst data_oe", 32'(mem_data_oe), 0);
        check("rst ack", 32'(wb_ack), 0);
        check("rst wb_dat_o", 32'(wb_dat_r), 0);
        check("rst clk_cre", 32'({mem_clk, mem_cre}), 0);
        cnt_any = 0;
        repeat (6) begin
            @(negedge clk);
            if ({mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n, mem_ub_n, mem_lb_n} != 6'h3F)
                cnt_any++;
        end
        check("idle no strobe", 32'(cnt_any), 0);

        // Fixed vectors
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, m);
            if (vecs[i].we) ref_write(vecs[i].adr, vecs[i].sel, vecs[i].dat);
            check_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, m, vecs[i].exp_addr,
                      vecs[i].exp_ub_n, vecs[i].exp_lb_n, vecs[i].exp_data);
        end

        // Random traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            adr = $urandom;
            if (adr[10:1] == 10'h080) adr[3] = ~adr[3];
            sel = 2'($urandom_range(0, 3));
            dat = 16'($urandom);
            run_txn(we, adr, sel, dat, m);
            if (we) ref_write(adr, sel, dat);
            check_txn($sformatf("rnd%0d", i), we, adr, m, adr[23:1], ~sel[1], ~sel[0],
                      ref_mem[adr[10:1]]);
        end

        // Back-to-back reads with stb held
        wb_we = 1'b0; wb_adr = 32'h0000_0246; wb_sel = 2'b11;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        prev_ce = 1'b1; acks = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (prev_ce && !mem_ce_n) falls.push_back(k);
            prev_ce = mem_ce_n;
            if (wb_ack) begin
                acks++;
                check("b2b rdata", 32'(wb_dat_r), 32'(ref_mem[10'h123]));
                if (acks == 2) begin
                    @(posedge clk);
                    #1;
                    wb_cyc = 1'b0; wb_stb = 1'b0;
                end
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check("b2b falls", 32'(falls.size()), 2);
        check("b2b spacing", (falls.size() >= 2) ? 32'(falls[1] - falls[0]) : 32'd0,
              RdN + 2 + Rec);
        check("b2b acks", 32'(acks), 2);

        // Reset on the second ACCESS cycle of a write
        wb_we = 1'b1; wb_adr = 32'h0000_0100; wb_sel = 2'b11; wb_dat_w = 16'h1357;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        check("rstmid we_n", 32'(mem_we_n), 1);
        check("rstmid data_oe", 32'(mem_data_oe), 0);
        check("rstmid ce_n", 32'(mem_ce_n), 1);
        check("rstmid data_o", 32'(mem_data_o), 0);
        check("rstmid wb_dat_o", 32'(wb_dat_r), 0);
        rst = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (wb_ack) acks++;
        end
        check("rstmid no ack", 32'(acks), 0);
        run_txn(1'b0, 32'h0000_0246, 2'b11, 16'h0000, m);
        check_txn("post_rst", 1'b0, 32'h0000_0246, m, 23'h000123, 1'b0, 1'b0, ref_mem[10'h123]);

        // Abort after one ACCESS cycle
        wb_we = 1'b0; wb_adr = 32'h0000_0246; wb_sel = 2'b11;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        cnt_ce = 0; cnt_oe = 0; acks = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
            if (!mem_ce_n) cnt_ce++;
            if (!mem_oe_n) cnt_oe++;
            if (wb_ack) acks++;
        end
        check("abort ce_low", 32'(cnt_ce), RdN);
        check("abort oe_low", 32'(cnt_oe), RdN);
        check("abort no ack", 32'(acks), 0);
        run_txn(1'b0, 32'h0000_0800, 2'b11, 16'h0000, m);
        check_txn("post_abort", 1'b0, 32'h0000_0800, m, 23'h000400, 1'b0, 1'b0, ref_mem[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
